simon_round_sequencer: RTL
==========================

// Module: simon_round_sequencer
// PURPOSE
//  Game-level scheduler above the tile graphics controller. Grows a random 4-tile pattern one step per round and
//  replays it through the graphics request port. Then collects and checks player presses, echoes correct presses as
//  flashes, and declares win/lose. Sits between the LFSR/key debouncer and the graphics control/datapath pair.
// PARAMETERS
//  MAX_LEN        16     maximum pattern length (rounds to win); 2..64
//  GAP_CYCLES     25_000_000 idle cycles after each playback flash completes
//  INPUT_TIMEOUT  250_000_000 cycles allowed between player presses before loss
// PORTS
//  clock          in   1   system clock, all state on rising edge
//  resetn         in   1   asynchronous active-low reset
//  start          in   1   level; sampled only in IDLE/WIN/LOSE, starts new game
//  rnd_tile       in   2   free-running LFSR tile value, sampled in EXTEND
//  user_valid     in   1   one-cycle pulse per debounced key press
//  user_tile      in   2   tile index pressed, valid with user_valid
//  gfx_req        out  1   request one flash of gfx_tile; held until gfx_done
//  gfx_tile       out  2   tile to flash; stable while gfx_req high
//  gfx_done       in   1   one-cycle pulse: flash and restore of previous tile finished
//  player_turn    out  1   high while in INPUT (enables key LEDs/echo)
//  round_len      out  7   current pattern length (0 in IDLE)
//  score          out  7   rounds fully completed this game
//  game_over      out  1   high in LOSE
//  game_won       out  1   high in WIN
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. Pattern memory contents don't-care. Reset mid-flash drops gfx_req immediately.
//  States / transitions (registered Moore outputs, one state per cycle minimum):
//   IDLE    : start -> CLEAR
//   CLEAR   : len<=0, score<=0 -> EXTEND
//   EXTEND  : mem[len]<=rnd_tile, len<=len+1, idx<=0 -> PLAY_REQ
//   PLAY_REQ: gfx_req=1, gfx_tile=mem[idx]; gfx_done -> PLAY_GAP (gap counter cleared)
//   PLAY_GAP: count GAP_CYCLES. At terminal: if idx==len-1 then idx<=0, timer<=0 -> INPUT; else idx++ -> PLAY_REQ
//   INPUT   : player_turn=1. user_valid & user_tile==mem[idx] -> ECHO. user_valid & mismatch -> LOSE.
//             Timer reaches INPUT_TIMEOUT-1 with no press -> LOSE
//   ECHO    : gfx_req=1, gfx_tile=captured user_tile; gfx_done -> NEXT
//   NEXT    : if idx==len-1: score<=len; if len==MAX_LEN -> WIN else -> EXTEND.
//             Otherwise idx++, timer<=0 -> INPUT
//   WIN/LOSE: hold flags; start -> CLEAR
//  user_valid outside INPUT is ignored (not queued). Presses during ECHO are dropped.
//  gfx_done outside PLAY_REQ/ECHO is ignored. gfx_done in same cycle as req rise is legal: 1-cycle handshake.
//  Simultaneous user_valid and timeout terminal in INPUT: the press wins.
//  Latency: EXTEND to first gfx_req = 1 cycle. Correct press to gfx_req = 1 cycle.
//  Widths: len, idx, score are 7 bits unsigned. Counters are sized by $clog2 of their parameter, saturate never (cleared on entry).
//  start held high in WIN/LOSE restarts once. It is ignored in all other states.
// STRUCTURE
//  Shared package simon_pkg: state encoding localparams, TILE_W=2, tile code constants (T0..T3).
//  Sub-module pattern_mem (MAX_LEN x 2 regs, 1 write port, 1 async read port addressed by idx); rest is flat FSM+counters.
// TESTING (bench params MAX_LEN=4, GAP_CYCLES=3, INPUT_TIMEOUT=20; gfx model returns gfx_done 5 cycles after req)
//  1 reset mid-PLAY_REQ -> gfx_req, player_turn, round_len, score all 0 next cycle; FSM in IDLE.
//  2 start, rnd_tile=2 -> one gfx_req with gfx_tile=2, round_len=1. After done+3 cycles, player_turn=1.
//  3 round 1 press user_tile=2 -> ECHO flash tile 2, score=1. Then round_len=2 and playback of mem[0], mem[1] in order.
//  4 press wrong tile (1 vs expected 3) -> game_over=1, no gfx_req, player_turn=0. start -> score=0, round_len=1.
//  5 no press for 20 cycles in INPUT -> game_over=1. Press on cycle 19 -> accepted, no loss.
//  6 rnd sequence 0,1,2,3, all correct -> game_won=1, score=4. Stray user_valid during playback changes nothing.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon round sequencer: tile width, tile codes,
// pattern length width and the FSM state encoding.
package simon_pkg;

  localparam int TILE_W = 2;
  localparam int LEN_W  = 7;

  localparam logic [TILE_W-1:0] T0 = 2'd0;
  localparam logic [TILE_W-1:0] T1 = 2'd1;
  localparam logic [TILE_W-1:0] T2 = 2'd2;
  localparam logic [TILE_W-1:0] T3 = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CLEAR    = 4'd1,
    S_EXTEND   = 4'd2,
    S_PLAY_REQ = 4'd3,
    S_PLAY_GAP = 4'd4,
    S_INPUT    = 4'd5,
    S_ECHO     = 4'd6,
    S_NEXT     = 4'd7,
    S_WIN      = 4'd8,
    S_LOSE     = 4'd9
  } state_t;

endpackage

// File: rtl/pattern_mem.sv
// Pattern storage: one write port, one asynchronous read port.
// Contents are never reset; a new game overwrites entries before reading them.
module pattern_mem
  import simon_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [TILE_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [TILE_W-1:0] rdata_o
);

  logic [TILE_W-1:0] mem_q [DEPTH];

  // Write the new tile at the addressed slot.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simon_round_sequencer.sv
// Simon game scheduler: grows a random tile pattern one step per round, replays
// it through the graphics request port, checks player presses and echoes the
// correct ones, and declares win or lose.
//
// state    | meaning
// IDLE     | after reset, waiting for start
// CLEAR    | zero length and score for a new game
// EXTEND   | append rnd_tile to the pattern, rewind playback index
// PLAY_REQ | flash mem[idx], wait for gfx_done
// PLAY_GAP | idle gap after a playback flash
// INPUT    | player's turn, waiting for press or timeout
// ECHO     | flash the tile just pressed
// NEXT     | advance index, or finish the round
// WIN      | all MAX_LEN rounds completed
// LOSE     | wrong press or timeout
module simon_round_sequencer
  import simon_pkg::*;
#(
  parameter int MAX_LEN       = 16,
  parameter int GAP_CYCLES    = 25_000_000,
  parameter int INPUT_TIMEOUT = 250_000_000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [TILE_W-1:0] rnd_tile,
  input  logic              user_valid,
  input  logic [TILE_W-1:0] user_tile,
  output logic              gfx_req,
  output logic [TILE_W-1:0] gfx_tile,
  input  logic              gfx_done,
  output logic              player_turn,
  output logic [LEN_W-1:0]  round_len,
  output logic [LEN_W-1:0]  score,
  output logic              game_over,
  output logic              game_won
);

  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TMO_W = (INPUT_TIMEOUT > 1) ? $clog2(INPUT_TIMEOUT) : 1;

  // Both timers count down from (N-1) to zero, so zero is the terminal cycle.
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(INPUT_TIMEOUT - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t state_q, state_d;

  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  score_q, score_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [TILE_W-1:0] echo_q, echo_d;

  logic [TILE_W-1:0] mem_rdata;
  logic              idx_last;
  logic              press_ok;

  assign idx_last = (idx_q == (len_q - LEN_W'(1)));
  assign press_ok = user_valid && (user_tile == mem_rdata);

  pattern_mem #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_pattern_mem (
    .clock   (clock),
    .we_i    (state_q == S_EXTEND),
    .waddr_i (len_q[AW-1:0]),
    .wdata_i (rnd_tile),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a press in the timeout terminal cycle takes priority.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: if (start) state_d = S_CLEAR;
      S_CLEAR:    state_d = S_EXTEND;
      S_EXTEND:   state_d = S_PLAY_REQ;
      S_PLAY_REQ: if (gfx_done) state_d = S_PLAY_GAP;
      S_PLAY_GAP: if (gap_q == '0) state_d = idx_last ? S_INPUT : S_PLAY_REQ;
      S_INPUT: begin
        if (user_valid)        state_d = press_ok ? S_ECHO : S_LOSE;
        else if (tmo_q == '0)  state_d = S_LOSE;
      end
      S_ECHO:     if (gfx_done) state_d = S_NEXT;
      S_NEXT: begin
        if (!idx_last)                state_d = S_INPUT;
        else if (len_q == MAX_LEN_L)  state_d = S_WIN;
        else                          state_d = S_EXTEND;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    gfx_req     = 1'b0;
    gfx_tile    = T0;
    player_turn = 1'b0;
    game_over   = 1'b0;
    game_won    = 1'b0;
    unique case (state_q)
      S_PLAY_REQ: begin
        gfx_req  = 1'b1;
        gfx_tile = mem_rdata;
      end
      S_ECHO: begin
        gfx_req  = 1'b1;
        gfx_tile = echo_q;
      end
      S_INPUT: player_turn = 1'b1;
      S_WIN:   game_won    = 1'b1;
      S_LOSE:  game_over   = 1'b1;
      default: ;
    endcase
  end

  assign round_len = len_q;
  assign score     = score_q;

  // Datapath next values: length, index, score, timers and echoed tile.
  always_comb begin
    len_d   = len_q;
    idx_d   = idx_q;
    score_d = score_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    echo_d  = echo_q;
    unique case (state_q)
      S_CLEAR: begin
        len_d   = '0;
        score_d = '0;
      end
      S_EXTEND: begin
        len_d = len_q + LEN_W'(1);
        idx_d = '0;
      end
      S_PLAY_REQ: if (gfx_done) gap_d = GAP_LOAD;
      S_PLAY_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (idx_last) begin
          idx_d = '0;
          tmo_d = TMO_LOAD;
        end else begin
          idx_d = idx_q + LEN_W'(1);
        end
      end
      S_INPUT: begin
        if (user_valid)        echo_d = user_tile;
        else if (tmo_q != '0)  tmo_d  = tmo_q - TMO_W'(1);
      end
      S_NEXT: begin
        if (idx_last) begin
          score_d = len_q;
        end else begin
          idx_d = idx_q + LEN_W'(1);
          tmo_d = TMO_LOAD;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      len_q   <= '0;
      idx_q   <= '0;
      score_q <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      echo_q  <= '0;
    end else begin
      len_q   <= len_d;
      idx_q   <= idx_d;
      score_q <= score_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      echo_q  <= echo_d;
    end
  end

endmodule
